// File: rtl/free_list_recovery_ctrl_pkg.sv
// Shared constants and types for the free-list recovery controller.
package free_list_recovery_ctrl_pkg;

  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned NUM_ARCH_REG = 32;
  localparam int unsigned PEND_DEPTH   = 4;

  localparam int unsigned PHYS_W = $clog2(NUM_PHYS_REG);
  localparam int unsigned ARCH_W = $clog2(NUM_ARCH_REG);
  localparam int unsigned PEND_W = $clog2(PEND_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StWalk,
    StDrain
  } recovery_state_t;

endpackage

// File: rtl/free_list_recovery_ctrl_pend_free_fifo.sv
// Small synchronous FIFO holding frees that arrive while the free list is being rebuilt.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module pend_free_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       empty_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, do_push, do_pop;

  // Occupancy flags and accept/drop decisions.
  always_comb begin
    empty_o = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push_i && (!full || do_pop);
    drop_o  = push_i && !do_push;
    count_o = wr_q - rd_q;
    head_o  = mem_q[rd_q[AW-1:0]];
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/free_list_recovery_ctrl.sv
// Sequences the physical-register free list: pass-through in normal operation,
// clear-then-walk rebuild from the retirement RAT after a ROB flush, with frees
// arriving during the rebuild parked in a FIFO and replayed afterwards.
module free_list_recovery_ctrl
  import free_list_recovery_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_flush_i,
  input  logic [PHYS_W-1:0] rrf_regs_i [NUM_ARCH_REG],
  input  logic              commit_free_valid_i,
  input  logic [PHYS_W-1:0] commit_free_reg_i,
  input  logic              dispatch_req_i,
  output logic              dispatch_grant_o,
  input  logic              fl_empty_i,
  output logic              fl_dequeue_o,
  output logic              fl_set_all_free_o,
  output logic              fl_mark_used_valid_o,
  output logic [PHYS_W-1:0] fl_mark_used_reg_o,
  output logic              fl_enqueue_o,
  output logic [PHYS_W-1:0] fl_freed_reg_o,
  output logic              recovery_busy_o,
  output logic              pend_overflow_o
);

  localparam logic [ARCH_W-1:0] LastIdx = ARCH_W'(NUM_ARCH_REG - 1);

  recovery_state_t   state_q, state_d;
  logic [ARCH_W-1:0] idx_q, idx_d;
  logic [PHYS_W-1:0] snap_q [NUM_ARCH_REG];
  logic              ovf_q;

  logic              push, pop, fifo_empty, fifo_drop;
  logic [PEND_W:0]   fifo_count;
  logic [PHYS_W-1:0] fifo_head;

  pend_free_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (PHYS_W)
  ) u_pend_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (commit_free_reg_i),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Next-state and free-list strobes; everything is held low during reset.
  always_comb begin
    state_d              = state_q;
    idx_d                = idx_q;
    push                 = 1'b0;
    pop                  = 1'b0;
    dispatch_grant_o     = 1'b0;
    fl_dequeue_o         = 1'b0;
    fl_set_all_free_o    = 1'b0;
    fl_mark_used_valid_o = 1'b0;
    fl_mark_used_reg_o   = '0;
    fl_enqueue_o         = 1'b0;
    fl_freed_reg_o       = '0;
    recovery_busy_o      = 1'b0;
    if (!rst) begin
      recovery_busy_o = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          dispatch_grant_o = dispatch_req_i && !fl_empty_i && !rob_flush_i;
          fl_dequeue_o     = dispatch_grant_o;
          fl_enqueue_o     = commit_free_valid_i && !rob_flush_i;
          fl_freed_reg_o   = commit_free_reg_i;
          // A free coincident with the flush would be wiped by the clear, so park it.
          push             = commit_free_valid_i && rob_flush_i;
        end
        StClear: begin
          fl_set_all_free_o = 1'b1;
          idx_d             = '0;
          push              = commit_free_valid_i;
          state_d           = StWalk;
        end
        StWalk: begin
          fl_mark_used_valid_o = 1'b1;
          fl_mark_used_reg_o   = snap_q[idx_q];
          idx_d                = idx_q + 1'b1;
          push                 = commit_free_valid_i;
          if (idx_q == LastIdx) state_d = (!fifo_empty || push) ? StDrain : StIdle;
        end
        StDrain: begin
          push = commit_free_valid_i;
          // Entries stay queued if a new flush is about to clear the list again.
          if (!fifo_empty && !rob_flush_i) begin
            pop            = 1'b1;
            fl_enqueue_o   = 1'b1;
            fl_freed_reg_o = fifo_head;
          end
          if (fifo_count == {{PEND_W{1'b0}}, pop} && !push) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (rob_flush_i) state_d = StClear;
    end
  end

  // Control state and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  // RRF snapshot taken in CLEAR so a commit coincident with the flush is included.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StClear) snap_q <= rrf_regs_i;
  end

  assign pend_overflow_o = ovf_q;

endmodule

// File: tb/tb_free_list_recovery_ctrl.sv
// Directed bench for the free-list recovery controller.
module tb_free_list_recovery_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rob_flush;
  logic [5:0] rrf [32];
  logic       cfv;
  logic [5:0] creg;
  logic       req;
  logic       grant;
  logic       fl_empty;
  logic       deq;
  logic       set_all;
  logic       mark_v;
  logic [5:0] mark_reg;
  logic       enq;
  logic [5:0] freed;
  logic       busy;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  free_list_recovery_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .rob_flush_i          (rob_flush),
    .rrf_regs_i           (rrf),
    .commit_free_valid_i  (cfv),
    .commit_free_reg_i    (creg),
    .dispatch_req_i       (req),
    .dispatch_grant_o     (grant),
    .fl_empty_i           (fl_empty),
    .fl_dequeue_o         (deq),
    .fl_set_all_free_o    (set_all),
    .fl_mark_used_valid_o (mark_v),
    .fl_mark_used_reg_o   (mark_reg),
    .fl_enqueue_o         (enq),
    .fl_freed_reg_o       (freed),
    .recovery_busy_o      (busy),
    .pend_overflow_o      (ovf)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rob_flush = 1'b0; cfv = 1'b0; creg = '0; req = 1'b0; fl_empty = 1'b0;
  endtask

  task automatic load_rrf();
    for (int i = 0; i < 32; i++) rrf[i] = 6'(i + 32);
  endtask

  task automatic test_reset();
    rst = 1'b1; rob_flush = 1'b1; cfv = 1'b1; creg = 6'd3; req = 1'b1; fl_empty = 1'b0;
    load_rrf();
    @(negedge clk);
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if ({set_all, mark_v, enq, deq} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {set_all, mark_v, enq, deq}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    rst = 1'b0; quiet();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL post_reset_ovf: got %b want 0", ovf); end
    checks++; if ({set_all, mark_v, enq, deq, grant} !== 5'b0) begin errors++; $display("FAIL post_reset_outs: got %b want 00000", {set_all, mark_v, enq, deq, grant}); end
  endtask

  task automatic test_dispatch();
    tick(); req = 1'b1; fl_empty = 1'b0;
    @(negedge clk);
    checks++; if ({grant, deq} !== 2'b11) begin errors++; $display("FAIL dispatch_grant: got %b want 11", {grant, deq}); end
    tick(); fl_empty = 1'b1;
    @(negedge clk);
    checks++; if ({grant, deq} !== 2'b00) begin errors++; $display("FAIL dispatch_empty: got %b want 00", {grant, deq}); end
    tick(); quiet();
  endtask

  task automatic test_commit_forward();
    cfv = 1'b1; creg = 6'd40;
    @(negedge clk);
    checks++; if (enq !== 1'b1 || freed !== 6'd40) begin errors++; $display("FAIL forward_free: got enq=%b reg=%0d want enq=1 reg=40", enq, freed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL forward_busy: got %b want 0", busy); end
    tick(); quiet();
  endtask

  task automatic test_flush_walk();
    req = 1'b1; rob_flush = 1'b1;                      // cycle T
    @(negedge clk);
    checks++; if (grant !== 1'b0 || set_all !== 1'b0) begin errors++; $display("FAIL flush_cycle: got grant=%b set_all=%b want 0 0", grant, set_all); end
    tick(); rob_flush = 1'b0;                          // T+1
    @(negedge clk);
    checks++; if (set_all !== 1'b1 || grant !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clear_cycle: got set_all=%b grant=%b busy=%b want 1 0 1", set_all, grant, busy); end
    tick();
    // Scramble the RRF after CLEAR: the walk must use the snapshot.
    for (int i = 0; i < 32; i++) rrf[i] = 6'd1;
    for (int k = 0; k < 32; k++) begin                 // T+2..T+33
      @(negedge clk);
      checks++;
      if (mark_v !== 1'b1 || mark_reg !== 6'(k + 32) || grant !== 1'b0) begin
        errors++;
        $display("FAIL walk_%0d: got v=%b reg=%0d grant=%b want 1 %0d 0", k, mark_v, mark_reg, grant, k + 32);
      end
      tick();
    end
    @(negedge clk);                                    // T+34
    checks++; if (busy !== 1'b0 || grant !== 1'b1 || mark_v !== 1'b0) begin errors++; $display("FAIL walk_exit: got busy=%b grant=%b mark=%b want 0 1 0", busy, grant, mark_v); end
    load_rrf();
    tick(); quiet();
  endtask

  task automatic test_pending_replay();
    rob_flush = 1'b1; cfv = 1'b1; creg = 6'd5;         // T
    @(negedge clk);
    checks++; if (enq !== 1'b0) begin errors++; $display("FAIL flush_free_not_forwarded: got %b want 0", enq); end
    for (int c = 1; c <= 33; c++) begin
      tick(); quiet();
      if (c == 10) begin cfv = 1'b1; creg = 6'd7; end
      @(negedge clk);
      if (c == 10) begin
        checks++; if (enq !== 1'b0) begin errors++; $display("FAIL walk_free_not_forwarded: got %b want 0", enq); end
      end
    end
    tick(); quiet();                                   // T+34
    @(negedge clk);
    checks++; if (enq !== 1'b1 || freed !== 6'd5 || busy !== 1'b1) begin errors++; $display("FAIL replay_first: got enq=%b reg=%0d busy=%b want 1 5 1", enq, freed, busy); end
    tick();                                            // T+35
    @(negedge clk);
    checks++; if (enq !== 1'b1 || freed !== 6'd7) begin errors++; $display("FAIL replay_second: got enq=%b reg=%0d want 1 7", enq, freed); end
    tick();                                            // T+36
    @(negedge clk);
    checks++; if (busy !== 1'b0 || enq !== 1'b0) begin errors++; $display("FAIL replay_exit: got busy=%b enq=%b want 0 0", busy, enq); end
    tick();
  endtask

  task automatic test_reflush();
    rob_flush = 1'b1;                                  // T
    for (int c = 1; c <= 55; c++) begin
      tick(); quiet();
      if (c == 5)  begin cfv = 1'b1; creg = 6'd9; end
      if (c == 20) rob_flush = 1'b1;
      @(negedge clk);
      if (c == 21) begin
        checks++; if (set_all !== 1'b1 || mark_v !== 1'b0) begin errors++; $display("FAIL reflush_clear: got set_all=%b mark=%b want 1 0", set_all, mark_v); end
      end
      if (c == 22) begin
        checks++; if (mark_v !== 1'b1 || mark_reg !== 6'd32) begin errors++; $display("FAIL reflush_restart: got v=%b reg=%0d want 1 32", mark_v, mark_reg); end
      end
      if (c == 53) begin
        checks++; if (mark_v !== 1'b1 || mark_reg !== 6'd63) begin errors++; $display("FAIL reflush_last: got v=%b reg=%0d want 1 63", mark_v, mark_reg); end
      end
      if (c == 54) begin
        checks++; if (enq !== 1'b1 || freed !== 6'd9) begin errors++; $display("FAIL reflush_replay: got enq=%b reg=%0d want 1 9", enq, freed); end
      end
      if (c == 55) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reflush_exit: got busy=%b want 0", busy); end
      end
    end
    tick();
  endtask

  task automatic test_overflow_and_reset();
    rob_flush = 1'b1;                                  // T
    for (int c = 1; c <= 38; c++) begin
      tick(); quiet();
      if (c >= 2 && c <= 6) begin cfv = 1'b1; creg = 6'(8 + c); end   // regs 10..14
      @(negedge clk);
      if (c == 6) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
      end
      if (c == 7) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
      end
      if (c >= 34 && c <= 37) begin
        checks++;
        if (enq !== 1'b1 || freed !== 6'(c - 24)) begin
          errors++;
          $display("FAIL ovf_replay_%0d: got enq=%b reg=%0d want 1 %0d", c, enq, freed, c - 24);
        end
      end
      if (c == 38) begin
        checks++; if (busy !== 1'b0 || enq !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_exit: got busy=%b enq=%b ovf=%b want 0 0 1", busy, enq, ovf); end
      end
    end
    // Reset in the middle of a walk with a pending free.
    tick(); rob_flush = 1'b1; cfv = 1'b1; creg = 6'd20;
    tick(); quiet();
    tick();
    tick(); rst = 1'b1; req = 1'b1;
    @(negedge clk);
    checks++; if ({set_all, mark_v, enq, deq, grant, busy} !== 6'b0) begin errors++; $display("FAIL rst_mid_walk: got %b want 000000", {set_all, mark_v, enq, deq, grant, busy}); end
    tick(); rst = 1'b0; quiet();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_cleared: got busy=%b ovf=%b want 0 0", busy, ovf); end
    // The FIFO must have been emptied: a fresh recovery exits straight to IDLE.
    rob_flush = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick(); quiet();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || enq !== 1'b0) begin errors++; $display("FAIL rst_fifo_empty: got busy=%b enq=%b want 0 0", busy, enq); end
    tick();
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_commit_forward();
    test_flush_walk();
    test_pending_replay();
    test_reflush();
    test_overflow_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
